// File: rtl/pc_unit.sv
// Fetch program counter for the IF stage: sequential stepping plus prioritised
// redirects, with redirects that arrive under stall held until it releases.
// Optional alignment check is enabled by defining PC_ALIGN_CHECK_EN.
module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int               STEP         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             fetch_valid,
  output logic             redirect_pend
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             pc_misalign
`endif
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic {RUN, PEND} state_t;

  state_t           state;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pend_q;
  logic [1:0]       sync_q;
  logic             live;
  logic             hi_req;
  logic             any_req;
  logic [WIDTH-1:0] hi_tgt;
  logic [WIDTH-1:0] sel_tgt;
  logic             align_ok;

  assign live    = sync_q[1];
  // Exception and ERET outrank a branch; exception outranks ERET.
  assign hi_req  = exc_req | eret_req;
  assign any_req = hi_req | br_valid;
  assign hi_tgt  = exc_req ? EXC_VECTOR : epc;
  assign sel_tgt = hi_req ? hi_tgt : br_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_VECTOR;
      pend_q <= '0;
      state  <= RUN;
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
      if (live) begin
        case (state)
          RUN: begin
            if (!stall) begin
              pc_q <= any_req ? sel_tgt : pc_q + STEP_W;
            end else if (any_req) begin
              pend_q <= sel_tgt;
              state  <= PEND;
            end
          end
          PEND: begin
            // A branch seen while a redirect is pending is on the wrong path.
            if (stall) begin
              if (hi_req) pend_q <= hi_tgt;
            end else begin
              pc_q  <= hi_req ? hi_tgt : pend_q;
              state <= RUN;
            end
          end
          default: state <= RUN;
        endcase
      end
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  assign pc_misalign = |pc_q[1:0];
  assign align_ok    = ~pc_misalign;
`else
  assign align_ok    = 1'b1;
`endif

  assign pc            = pc_q;
  assign pc_plus       = pc_q + STEP_W;
  assign redirect_pend = (state == PEND);
  assign fetch_valid   = live & ~stall & (state == RUN) & align_ok;

endmodule
